// File: rtl/sram_line_responder.sv
// sram_line_responder: serves one cache-line read fill or write-back
// as a burst of narrow beats on a pipelined backing-memory bus.
module sram_line_responder #(
  parameter int SRAM_DATA_BIT = 256,
  parameter int SRAM_ADDR_BIT = 11,
  parameter int BEAT_BIT      = 32
) (
  input  logic clk_sys_i,
  input  logic rst_n_i,
  input  logic SRAM_ena_i,
  input  logic SRAM_wea_i,
  input  logic [SRAM_ADDR_BIT-1:0] SRAM_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] SRAM_data_i,
  output logic [SRAM_DATA_BIT-1:0] SRAM_data_o,
  output logic SRAM_ack_o,
  output logic busy_o,
  output logic mem_req_o,
  output logic mem_we_o,
  output logic [SRAM_ADDR_BIT+$clog2(SRAM_DATA_BIT/BEAT_BIT)-1:0]
               mem_addr_o,
  output logic [BEAT_BIT-1:0] mem_wdata_o,
  input  logic mem_gnt_i,
  input  logic mem_rvalid_i,
  input  logic [BEAT_BIT-1:0] mem_rdata_i
);

  localparam int BEATS   = SRAM_DATA_BIT / BEAT_BIT;
  localparam int CNT_BIT = $clog2(BEATS);

  localparam logic [CNT_BIT:0] BEATS_C = (CNT_BIT+1)'(BEATS);
  localparam logic [CNT_BIT:0] LAST_C  = (CNT_BIT+1)'(BEATS - 1);
  localparam logic [CNT_BIT:0] ONE_C   = (CNT_BIT+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_BIT:0] issue_cnt, issue_nxt;
  logic [CNT_BIT:0] rcv_cnt, rcv_nxt;
  logic [SRAM_ADDR_BIT-1:0] line_addr, addr_nxt;
  logic [SRAM_DATA_BIT-1:0] wline, wline_nxt;
  logic [SRAM_DATA_BIT-1:0] rline, rline_nxt;
  logic [CNT_BIT-1:0] issue_idx;
  logic [CNT_BIT-1:0] rcv_idx;
  logic grant;
  logic issuing;

  assign grant     = mem_req_o & mem_gnt_i;
  assign rcv_idx   = rcv_cnt[CNT_BIT-1:0];
  assign issue_idx = issue_nxt[CNT_BIT-1:0];
  assign issuing   = issue_nxt < BEATS_C;

  assign SRAM_ack_o = (state == DONE);
  assign busy_o     = (state != IDLE);

  // State register
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, counters, latched request and line assembly
  always_comb begin
    state_nxt = state;
    issue_nxt = issue_cnt;
    rcv_nxt   = rcv_cnt;
    addr_nxt  = line_addr;
    wline_nxt = wline;
    rline_nxt = rline;
    unique case (state)
      IDLE: begin
        if (SRAM_ena_i) begin
          addr_nxt  = SRAM_addr_i;
          if (SRAM_wea_i) wline_nxt = SRAM_data_i;
          state_nxt = SRAM_wea_i ? WR : RD;
          issue_nxt = '0;
          rcv_nxt   = '0;
        end
      end
      RD: begin
        if (grant) issue_nxt = issue_cnt + ONE_C;
        // a beat nobody asked for is dropped
        if (mem_rvalid_i && rcv_cnt < issue_cnt) begin
          rline_nxt[rcv_idx*BEAT_BIT +: BEAT_BIT] = mem_rdata_i;
          rcv_nxt = rcv_cnt + ONE_C;
          if (rcv_cnt == LAST_C) state_nxt = DONE;
        end
      end
      WR: begin
        if (grant) begin
          issue_nxt = issue_cnt + ONE_C;
          if (issue_cnt == LAST_C) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers and registered bus outputs
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      issue_cnt   <= '0;
      rcv_cnt     <= '0;
      line_addr   <= '0;
      wline       <= '0;
      rline       <= '0;
      SRAM_data_o <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      issue_cnt   <= issue_nxt;
      rcv_cnt     <= rcv_nxt;
      line_addr   <= addr_nxt;
      wline       <= wline_nxt;
      rline       <= rline_nxt;
      mem_req_o   <= (state_nxt == RD || state_nxt == WR) && issuing;
      mem_we_o    <= (state_nxt == WR) && issuing;
      mem_addr_o  <= {addr_nxt, issue_idx};
      mem_wdata_o <= wline_nxt[issue_idx*BEAT_BIT +: BEAT_BIT];
      if (state == RD && state_nxt == DONE) SRAM_data_o <= rline_nxt;
    end
  end

endmodule

// File: tb/tb_sram_line_responder.sv
// tb_sram_line_responder: random-stimulus bench with a word-addressed
// memory model acting as the backing bus slave.
module tb_sram_line_responder;

  localparam int DW    = 256;
  localparam int AW    = 11;
  localparam int BW    = 32;
  localparam int BEATS = 8;
  localparam int MAW   = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ena = 1'b0;
  logic wea = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] line_in = '0;
  logic [DW-1:0] data_o;
  logic ack, busy, mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic mem_gnt, mem_rvalid;
  logic [BW-1:0] mem_rdata;

  sram_line_responder dut (
    .clk_sys_i(clk), .rst_n_i(rst_n),
    .SRAM_ena_i(ena), .SRAM_wea_i(wea),
    .SRAM_addr_i(addr), .SRAM_data_i(line_in),
    .SRAM_data_o(data_o), .SRAM_ack_o(ack), .busy_o(busy),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [BW-1:0] model [0:(1<<MAW)-1];
  int gnt_mode = 0;
  int rv_delay = 1;
  bit spur_en = 1'b0;
  logic [MAW-1:0] rq_addr[$];
  int rq_due[$];
  logic [MAW-1:0] g_addr[$];
  logic g_we[$];
  logic [BW-1:0] g_data[$];
  int stall_bad = 0;
  bit prev_stall = 1'b0;
  logic [MAW-1:0] prev_addr;
  logic prev_we;
  int ack_cnt = 0;
  int last_ack_cyc = 0;
  int c0, a0, g0;
  logic [DW-1:0] last_read = '0;

  // Backing-memory slave: grant policy, in-order delayed read returns
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata = model[rq_addr[0]];
        void'(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end else if (spur_en && rq_due.size() == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      case (gnt_mode)
        0: mem_gnt = 1'b1;
        1: mem_gnt = (cyc % 2 == 0);
        default: mem_gnt = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (ack) begin
        ack_cnt++;
        last_ack_cyc = cyc;
      end
      if (mem_req) begin
        if (prev_stall && (mem_addr !== prev_addr || mem_we !== prev_we))
          stall_bad++;
        if (mem_gnt) begin
          g_addr.push_back(mem_addr);
          g_we.push_back(mem_we);
          g_data.push_back(mem_wdata);
          if (mem_we) model[mem_addr] = mem_wdata;
          else begin
            int due;
            due = cyc + rv_delay;
            if (rq_due.size() > 0 && due < rq_due[$]) due = rq_due[$];
            rq_addr.push_back(mem_addr);
            rq_due.push_back(due);
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_addr = mem_addr;
          prev_we = mem_we;
        end
      end else begin
        if (prev_stall) stall_bad++;
        prev_stall = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] model_line(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < BEATS; k++) r[k*BW +: BW] = model[{a, 3'(k)}];
    return r;
  endfunction

  function automatic int grant_errs(input bit we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] line);
    int e;
    e = 0;
    if (g_addr.size() != g0 + BEATS) e++;
    for (int k = 0; k < BEATS; k++) begin
      if (g0 + k < g_addr.size()) begin
        if (g_addr[g0+k] !== {a, 3'(k)}) e++;
        if (g_we[g0+k] !== we) e++;
        if (we && g_data[g0+k] !== line[k*BW +: BW]) e++;
      end
    end
    return e;
  endfunction

  task automatic start_req(input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] line);
    @(posedge clk); #2;
    ena = 1'b1;
    wea = we;
    addr = a;
    line_in = line;
    c0 = cyc;
    a0 = ack_cnt;
    g0 = g_addr.size();
  endtask

  // returns in the cycle after the ack with ena still high
  task automatic wait_ack(output int lat);
    int t;
    t = 0;
    lat = -1;
    while (1) begin
      @(posedge clk); #2;
      t++;
      if (t == 1) begin
        addr = ~addr;
        line_in = ~line_in;
        wea = ~wea;
      end
      if (ack_cnt != a0) begin
        lat = last_ack_cyc - c0;
        break;
      end
      if (t > 300) begin
        checks++;
        failures++;
        $display("FAIL ack_timeout: no ack after %0d cycles", t);
        break;
      end
    end
  endtask

  task automatic finish_req(input string nm);
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (ack_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL %s_ack_count: got %0d expected 1", nm, ack_cnt - a0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, busy, mem_req, mem_we} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {ack, busy, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_bus: got %h/%h expected 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (data_o !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_basic();
    int lat;
    logic [DW-1:0] exp;
    gnt_mode = 0;
    rv_delay = 1;
    for (int k = 0; k < BEATS; k++) model[14'h028 + k] = 32'h00A0 + k;
    exp = '0;
    for (int k = 0; k < BEATS; k++) exp[k*BW +: BW] = 32'h00A0 + k;
    start_req(1'b0, 11'h005, '0);
    wait_ack(lat);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL rd_latency: got %0d expected 10", lat);
    end
    checks++;
    if (grant_errs(1'b0, 11'h005, '0) !== 0) begin
      failures++;
      $display("FAIL rd_addrs: got %0d errors expected 0",
               grant_errs(1'b0, 11'h005, '0));
    end
    checks++;
    if (data_o !== exp) begin
      failures++;
      $display("FAIL rd_data: got %h expected %h", data_o, exp);
    end
    last_read = exp;
    finish_req("rd");
  endtask

  task automatic test_read_stall();
    int lat;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    gnt_mode = 1;
    rv_delay = 3;
    stall_bad = 0;
    a = AW'($urandom);
    exp = model_line(a);
    start_req(1'b0, a, '0);
    wait_ack(lat);
    checks++;
    if (data_o !== exp) begin
      failures++;
      $display("FAIL stall_data: got %h expected %h", data_o, exp);
    end
    checks++;
    if (grant_errs(1'b0, a, '0) !== 0) begin
      failures++;
      $display("FAIL stall_addrs: got %0d errors expected 0",
               grant_errs(1'b0, a, '0));
    end
    checks++;
    if (stall_bad !== 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d unstable stalls expected 0",
               stall_bad);
    end
    last_read = exp;
    finish_req("stall");
  endtask

  task automatic test_write();
    int lat;
    logic [DW-1:0] line;
    gnt_mode = 0;
    rv_delay = 1;
    for (int k = 0; k < BEATS; k++) line[k*BW +: BW] = 32'h1111 * (k + 1);
    start_req(1'b1, 11'h3FF, line);
    wait_ack(lat);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL wr_latency: got %0d expected 9", lat);
    end
    checks++;
    if (grant_errs(1'b1, 11'h3FF, line) !== 0) begin
      failures++;
      $display("FAIL wr_beats: got %0d errors expected 0",
               grant_errs(1'b1, 11'h3FF, line));
    end
    checks++;
    if (data_o !== last_read) begin
      failures++;
      $display("FAIL wr_keeps_data: got %h expected %h", data_o, last_read);
    end
    finish_req("wr");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [DW-1:0] exp1, exp2;
    gnt_mode = 0;
    rv_delay = 1;
    exp1 = model_line(11'h3FF);
    exp2 = model_line(11'h123);
    start_req(1'b0, 11'h3FF, '0);
    wait_ack(lat);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_accept_in_done: got req %b expected 0", mem_req);
    end
    checks++;
    if (data_o !== exp1 || lat !== 10) begin
      failures++;
      $display("FAIL b2b_first: got %h lat %0d expected %h lat 10",
               data_o, lat, exp1);
    end
    addr = 11'h123;
    wea = 1'b0;
    c0 = cyc;
    a0 = ack_cnt;
    g0 = g_addr.size();
    wait_ack(lat);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d expected 10", lat);
    end
    checks++;
    if (data_o !== exp2 || grant_errs(1'b0, 11'h123, '0) !== 0) begin
      failures++;
      $display("FAIL b2b_second: got %h expected %h", data_o, exp2);
    end
    last_read = exp2;
    finish_req("b2b");
  endtask

  task automatic test_reset_mid();
    int t, lat;
    logic [DW-1:0] exp;
    gnt_mode = 0;
    rv_delay = 3;
    start_req(1'b0, 11'h0AA, '0);
    t = 0;
    while (g_addr.size() < g0 + 4 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    rst_n = 1'b0;
    ena = 1'b0;
    #1;
    checks++;
    if ({ack, busy, mem_req, mem_we} !== 4'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || data_o !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got %b %h %h %h expected all zero",
               {ack, busy, mem_req, mem_we}, mem_addr, mem_wdata, data_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spur_en = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (ack_cnt !== a0 || busy !== 1'b0 || data_o !== '0) begin
      failures++;
      $display("FAIL midreset_stray: got acks %0d busy %b data %h expected 0 0 0",
               ack_cnt - a0, busy, data_o);
    end
    spur_en = 1'b0;
    @(posedge clk); #3;
    rq_addr.delete();
    rq_due.delete();
    rv_delay = 1;
    exp = model_line(11'h0AA);
    start_req(1'b0, 11'h0AA, '0);
    wait_ack(lat);
    checks++;
    if (data_o !== exp || lat !== 10) begin
      failures++;
      $display("FAIL midreset_fresh: got %h lat %0d expected %h lat 10",
               data_o, lat, exp);
    end
    last_read = exp;
    finish_req("fresh");
  endtask

  task automatic test_spurious();
    int lat;
    logic [DW-1:0] exp;
    gnt_mode = 2;
    rv_delay = 2;
    a0 = ack_cnt;
    spur_en = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (data_o !== last_read || busy !== 1'b0 || ack_cnt !== a0) begin
      failures++;
      $display("FAIL idle_spurious: got %h busy %b expected %h busy 0",
               data_o, busy, last_read);
    end
    exp = model_line(11'h055);
    start_req(1'b0, 11'h055, '0);
    wait_ack(lat);
    checks++;
    if (data_o !== exp) begin
      failures++;
      $display("FAIL extra_rvalid: got %h expected %h", data_o, exp);
    end
    last_read = exp;
    spur_en = 1'b0;
    finish_req("spur");
  endtask

  task automatic test_random();
    int lat;
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] line, exp;
    gnt_mode = 2;
    stall_bad = 0;
    for (int n = 0; n < 14; n++) begin
      we = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 7));
      for (int k = 0; k < BEATS; k++) line[k*BW +: BW] = $urandom;
      rv_delay = $urandom_range(1, 4);
      exp = we ? last_read : model_line(a);
      start_req(we, a, line);
      wait_ack(lat);
      checks++;
      if (grant_errs(we, a, line) !== 0) begin
        failures++;
        $display("FAIL rand_beats_%0d: got %0d errors expected 0",
                 n, grant_errs(we, a, line));
      end
      checks++;
      if (data_o !== exp) begin
        failures++;
        $display("FAIL rand_data_%0d: got %h expected %h", n, data_o, exp);
      end
      last_read = exp;
      finish_req("rand");
    end
    checks++;
    if (stall_bad !== 0) begin
      failures++;
      $display("FAIL rand_stall_hold: got %0d expected 0", stall_bad);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << MAW); i++) model[i] = $urandom;
    test_reset();
    test_read_basic();
    test_read_stall();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_line_responder.md
Name: sram_line_responder

Overview:
- Memory-side responder for the instruction/data cache line-fill interface.
- Accepts one full-line request (read fill or write-back) from a cache's SRAM port.
- Serves the request as a burst of narrow beats on a pipelined backing-memory bus, then returns the assembled line with a one-cycle acknowledge.
- Sits between each Cache_sets instance and the on-chip/off-chip memory arbiter.

Parameters:
- SRAM_DATA_BIT, 256, line width in bits on the cache side.
- SRAM_ADDR_BIT, 11, line address width on the cache side.
- BEAT_BIT, 32, backing-memory beat width. SRAM_DATA_BIT must be a power-of-two multiple of BEAT_BIT.
- Derived localparams:
  - BEATS = SRAM_DATA_BIT/BEAT_BIT
  - CNT_BIT = $clog2(BEATS)
  - MEM_ADDR_BIT = SRAM_ADDR_BIT + CNT_BIT

Ports:
- clk_sys_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- SRAM_ena_i  in  1  line request; held by cache until SRAM_ack_o
- SRAM_wea_i  in  1  1 = write line, 0 = read line
- SRAM_addr_i  in  SRAM_ADDR_BIT  line address
- SRAM_data_i  in  SRAM_DATA_BIT  write line data
- SRAM_data_o  out  SRAM_DATA_BIT  read line data
- SRAM_ack_o  out  1  one-cycle completion pulse
- busy_o  out  1  request in progress (state != IDLE)
- mem_req_o  out  1  beat request
- mem_we_o  out  1  beat write enable
- mem_addr_o  out  MEM_ADDR_BIT  beat address = {line_addr, beat index}
- mem_wdata_o  out  BEAT_BIT  write beat
- mem_gnt_i  in  1  beat accepted this cycle when mem_req_o=1; may be combinational
- mem_rvalid_i  in  1  read beat returning, in issue order
- mem_rdata_i  in  BEAT_BIT  read beat data

Behaviour:
- Reset (async, rst_n_i=0):
  - State = IDLE; issue/receive counters = 0.
  - SRAM_ack_o = 0, busy_o = 0, mem_req_o = 0, mem_we_o = 0.
  - mem_addr_o = 0, mem_wdata_o = 0, SRAM_data_o = 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - If SRAM_ena_i=1, latch addr, wea and write line (write line only when wea=1).
  - Go to WR if wea=1, else RD. Clear both counters.
  - mem_rvalid_i is ignored in IDLE.
- RD:
  - mem_req_o=1 and mem_we_o=0 while issue count < BEATS.
  - mem_addr_o = {line_addr, issue_cnt}.
  - Each cycle with mem_req_o & mem_gnt_i increments issue_cnt.
  - Each mem_rvalid_i writes mem_rdata_i into line buffer bits [rcv_cnt*BEAT_BIT +: BEAT_BIT] (beat 0 = LSBs, little-endian) and increments rcv_cnt.
  - Up to BEATS beats may be outstanding.
  - mem_rvalid_i arriving when rcv_cnt >= issue_cnt is a protocol error; it is dropped and not captured.
  - On rvalid with rcv_cnt = BEATS-1, go to DONE.
- WR:
  - mem_req_o=1 and mem_we_o=1 while issue count < BEATS.
  - mem_wdata_o = latched line slice [issue_cnt*BEAT_BIT +: BEAT_BIT].
  - Increment on grant. On grant with issue_cnt = BEATS-1, go to DONE.
  - No rvalid is expected for writes.
- DONE:
  - SRAM_ack_o=1 for exactly this cycle.
  - For a read, SRAM_data_o is updated from the line buffer on entry to DONE and holds until the next read completes. Writes leave SRAM_data_o unchanged.
  - Always return to IDLE next cycle. SRAM_ena_i is not sampled in DONE, so the next request is accepted no earlier than the cycle after the ack.
- mem_req_o deasserts in the cycle after the last grant; request signals are registered.
- Counter widths: issue_cnt and rcv_cnt are CNT_BIT+1 bits so the value BEATS is representable; beat index uses the low CNT_BIT bits.
- Changes to SRAM_addr_i, SRAM_wea_i or SRAM_data_i after acceptance have no effect until the next request.
- Latency (zero-wait grant, rvalid one cycle after grant, BEATS=8):
  - Request sampled in cycle 0; beats issued cycles 1..8.
  - rvalid in cycles 2..9; ack in cycle 10, i.e. BEATS+2 cycles after sampling.
- Write latency: ack in cycle BEATS+1.
- Reset mid-burst aborts the request immediately: no ack, counters and state cleared.
- Stale mem_rvalid_i after reset is ignored because the block is in IDLE.

Test Plan:
- Read, gnt tied 1, rvalid one cycle later, beat k of line 0x005 = 0x00A0+k:
  - mem_addr_o issues 0x028..0x02F.
  - ack in cycle 10.
  - SRAM_data_o = {0x00A7,...,0x00A0}, with 0x00A0 in bits [31:0].
- Read with gnt low on odd cycles and rvalid delayed 3 cycles:
  - Line data still assembled in order.
  - Exactly one ack.
  - mem_req_o held with a stable address while ungranted.
- Write of line 0x3FF with data 0x1111..8888 per beat:
  - 8 granted beats at addresses 0x1FF8..0x1FFF, mem_we_o=1, wdata beat k = slice k.
  - Ack in cycle 9.
  - SRAM_data_o unchanged from the previous read.
- SRAM_ena_i held high through ack and then the address changed:
  - No request accepted in the DONE cycle.
  - The new request is accepted in the cycle after the ack.
- rst_n_i pulsed low after beat 3 of a read:
  - All outputs return to reset values asynchronously.
  - No ack is produced.
  - Subsequent stray rvalid pulses are ignored.
  - A fresh read then completes normally.
- Spurious mem_rvalid_i in IDLE and an extra rvalid beyond the issued count:
  - Neither is captured.
  - SRAM_data_o and the counters are unaffected.
